// File: rtl/board_engine_nxn.sv
// NxN two-player board engine: accepts moves over valid/ready, alternates turns,
// and scans one direction per cycle for a K-in-a-row win or a full-board draw.
module board_engine_nxn #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int IW = $clog2(N*N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           move_valid,
  input  logic [IW-1:0]  move_idx,
  output logic           move_ready,
  output logic           move_err,
  output logic           turn,
  output logic [N*N-1:0] p1_board,
  output logic [N*N-1:0] p2_board,
  output logic           p1win,
  output logic           p2win,
  output logic           draw,
  output logic           game_over
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = $clog2(N*N + 1);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  state_t          state;
  logic [1:0]      dir;
  logic [IW-1:0]   last_idx;
  logic [CW-1:0]   move_count;

  logic            in_range;
  logic            legal;
  logic [IW-1:0]   safe_idx;
  logic [NN-1:0]   occupied;
  logic [NN-1:0]   cell_mask;
  logic [NN-1:0]   mine;
  logic            hit;
  logic            board_full;

  // Move legality: index on the board and cell free in both boards
  always_comb begin
    occupied  = p1_board | p2_board;
    in_range  = ({1'b0, move_idx} < (IW+1)'(NN));
    safe_idx  = in_range ? move_idx : '0;
    legal     = in_range && !occupied[safe_idx];
    cell_mask = NN'(1) << move_idx;
    board_full = (move_count == CW'(NN));
  end

  // Run length through last_idx along the current direction, bounded to K-1 per side
  int   row, col, dr, dc, rr, cc, cidx, run;
  logic cont, inb;

  always_comb begin
    mine = turn ? p2_board : p1_board;
    row  = int'(last_idx) / N;
    col  = int'(last_idx) % N;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    run  = 1;
    cont = 1'b0;
    inb  = 1'b0;
    rr   = 0;
    cc   = 0;
    cidx = 0;
    for (int side = 0; side < 2; side++) begin
      cont = 1'b1;
      for (int s = 1; s < K; s++) begin
        rr   = (side == 0) ? row + dr * s : row - dr * s;
        cc   = (side == 0) ? col + dc * s : col - dc * s;
        inb  = (rr >= 0) && (rr < N) && (cc >= 0) && (cc < N);
        cidx = inb ? rr * N + cc : 0;
        if (cont && inb && mine[IW'(cidx)]) run = run + 1;
        else cont = 1'b0;
      end
    end
    hit = (run >= K);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= 2'd0;
      last_idx   <= '0;
      move_count <= '0;
      move_ready <= 1'b0;
      move_err   <= 1'b0;
      turn       <= 1'b0;
      p1_board   <= '0;
      p2_board   <= '0;
      p1win      <= 1'b0;
      p2win      <= 1'b0;
      draw       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      move_err <= 1'b0;
      if (clear) begin
        // New game wins over any move or scan in flight
        state      <= IDLE;
        dir        <= 2'd0;
        move_count <= '0;
        move_ready <= 1'b1;
        turn       <= 1'b0;
        p1_board   <= '0;
        p2_board   <= '0;
        p1win      <= 1'b0;
        p2win      <= 1'b0;
        draw       <= 1'b0;
        game_over  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            move_ready <= 1'b1;
            if (move_valid && move_ready) begin
              if (legal) begin
                if (turn) p2_board <= p2_board | cell_mask;
                else      p1_board <= p1_board | cell_mask;
                move_count <= move_count + 1'b1;
                last_idx   <= move_idx;
                dir        <= 2'd0;
                move_ready <= 1'b0;
                state      <= CHECK;
              end else begin
                move_err <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (hit) begin
              if (turn) p2win <= 1'b1;
              else      p1win <= 1'b1;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (dir == 2'd3) begin
              if (board_full) begin
                draw      <= 1'b1;
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                turn       <= ~turn;
                move_ready <= 1'b1;
                state      <= IDLE;
              end
            end else begin
              dir <= dir + 2'd1;
            end
          end
          OVER: begin
            move_ready <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            move_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
